// File: rtl/tx_mem_reader_pkg.sv
// Shared constants and FSM encoding for the TX memory read engine.
package tx_mem_reader_pkg;

   localparam int DEF_DATA_WIDTH = 32;
   localparam int DEF_MEM_DEPTH  = 16;
   localparam int DEF_ADDR_WIDTH = 4;
   localparam int DEF_LEN_WIDTH  = DEF_ADDR_WIDTH + 1;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_FETCH = 2'd1,
      ST_DRAIN = 2'd2
   } rd_state_t;

endpackage

// File: rtl/tx_mem_reader_if.sv
// Control, memory-port and TX-stream signals of the read engine.
interface tx_mem_reader_if
   import tx_mem_reader_pkg::*;
#(
   parameter int DATA_WIDTH = DEF_DATA_WIDTH,
   parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
   parameter int LEN_WIDTH  = DEF_LEN_WIDTH
);

   logic                  start;
   logic [ADDR_WIDTH-1:0] start_addr;
   logic [LEN_WIDTH-1:0]  length;
   logic                  abort;
   logic                  busy;
   logic                  done;
   logic [ADDR_WIDTH-1:0] mem_addr;
   logic                  mem_wr;
   logic [DATA_WIDTH-1:0] mem_rdata;
   logic [DATA_WIDTH-1:0] tx_data;
   logic                  tx_valid;
   logic                  tx_ready;
   logic                  tx_last;

   modport master (
      input  start, start_addr, length, abort, mem_rdata, tx_ready,
      output busy, done, mem_addr, mem_wr, tx_data, tx_valid, tx_last
   );

   modport slave (
      output start, start_addr, length, abort, mem_rdata, tx_ready,
      input  busy, done, mem_addr, mem_wr, tx_data, tx_valid, tx_last
   );

endinterface

// File: rtl/tx_mem_reader_skid_fifo.sv
// Two-entry FIFO used as the output buffer; flush empties it in one cycle.
module tx_skid_fifo #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             flush,
   input  logic             push,
   input  logic [WIDTH-1:0] push_data,
   input  logic             pop,
   output logic [WIDTH-1:0] pop_data,
   output logic [1:0]       count
);

   logic [1:0][WIDTH-1:0] entry_q;
   logic                  wr_ptr_reg;
   logic                  rd_ptr_reg;
   logic [1:0]            count_reg;

   generate
      for (genvar gi = 0; gi < 2; gi++) begin : g_entry
         logic [WIDTH-1:0] data_reg;

         always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
               data_reg <= '0;
            end else if (push && !flush && (wr_ptr_reg == 1'(gi))) begin
               data_reg <= push_data;
            end
         end

         assign entry_q[gi] = data_reg;
      end
   endgenerate

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         wr_ptr_reg <= 1'b0;
         rd_ptr_reg <= 1'b0;
         count_reg  <= 2'd0;
      end else if (flush) begin
         wr_ptr_reg <= 1'b0;
         rd_ptr_reg <= 1'b0;
         count_reg  <= 2'd0;
      end else begin
         if (push) begin
            wr_ptr_reg <= ~wr_ptr_reg;
         end
         if (pop) begin
            rd_ptr_reg <= ~rd_ptr_reg;
         end
         count_reg <= count_reg + 2'(push) - 2'(pop);
      end
   end

   assign pop_data = entry_q[rd_ptr_reg];
   assign count    = count_reg;

endmodule

// File: rtl/tx_mem_reader.sv
// Streams `length` words from the TX memory read port to the serializer,
// hiding the one-cycle read latency behind a two-entry output buffer.
module tx_mem_reader
   import tx_mem_reader_pkg::*;
#(
   parameter int DATA_WIDTH = DEF_DATA_WIDTH,
   parameter int MEM_DEPTH  = DEF_MEM_DEPTH,
   parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
   parameter int LEN_WIDTH  = DEF_LEN_WIDTH
) (
   input  logic            clk,
   input  logic            reset_n,
   tx_mem_reader_if.master bus
);

   rd_state_t             state_reg;
   logic [ADDR_WIDTH-1:0] addr_reg;
   logic [ADDR_WIDTH-1:0] addr_next;
   logic [LEN_WIDTH-1:0]  len_reg;
   logic [LEN_WIDTH-1:0]  issue_cnt_reg;
   logic [LEN_WIDTH-1:0]  send_cnt_reg;
   logic [LEN_WIDTH-1:0]  req_len;
   logic                  inflight_reg;
   logic                  busy_reg;
   logic                  done_reg;

   logic [1:0]            fifo_count;
   logic [DATA_WIDTH-1:0] head_data;
   logic                  tx_valid_int;
   logic                  pop;
   logic                  issue;
   logic                  last_issue;
   logic                  last_pop;
   logic [2:0]            occupancy;

   assign req_len = (bus.length > LEN_WIDTH'(MEM_DEPTH)) ? LEN_WIDTH'(MEM_DEPTH) : bus.length;

   assign tx_valid_int = (fifo_count != 2'd0);
   assign pop          = tx_valid_int && bus.tx_ready;

   // A read issued now lands in the buffer at the end of the next cycle, so the
   // buffer plus the word already on mem_rdata must leave room for it.
   assign occupancy  = {1'b0, fifo_count} + {2'b00, inflight_reg} - {2'b00, pop};
   assign issue      = (state_reg == ST_FETCH) && !bus.abort && (occupancy < 3'd2);
   assign last_issue = (issue_cnt_reg == len_reg - LEN_WIDTH'(1));
   assign last_pop   = (send_cnt_reg == len_reg - LEN_WIDTH'(1));

   assign addr_next = (addr_reg == ADDR_WIDTH'(MEM_DEPTH - 1)) ? '0 : addr_reg + ADDR_WIDTH'(1);

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_reg     <= ST_IDLE;
         addr_reg      <= '0;
         len_reg       <= '0;
         issue_cnt_reg <= '0;
         send_cnt_reg  <= '0;
         inflight_reg  <= 1'b0;
         busy_reg      <= 1'b0;
         done_reg      <= 1'b0;
      end else begin
         done_reg     <= 1'b0;
         inflight_reg <= issue;
         if (bus.abort) begin
            state_reg     <= ST_IDLE;
            busy_reg      <= 1'b0;
            issue_cnt_reg <= '0;
            send_cnt_reg  <= '0;
         end else begin
            case (state_reg)
               ST_IDLE: begin
                  if (bus.start) begin
                     if (req_len == '0) begin
                        done_reg <= 1'b1;
                     end else begin
                        state_reg     <= ST_FETCH;
                        busy_reg      <= 1'b1;
                        addr_reg      <= bus.start_addr;
                        len_reg       <= req_len;
                        issue_cnt_reg <= '0;
                        send_cnt_reg  <= '0;
                     end
                  end
               end
               ST_FETCH: begin
                  if (issue) begin
                     addr_reg      <= addr_next;
                     issue_cnt_reg <= issue_cnt_reg + LEN_WIDTH'(1);
                     if (last_issue) begin
                        state_reg <= ST_DRAIN;
                     end
                  end
                  if (pop) begin
                     send_cnt_reg <= send_cnt_reg + LEN_WIDTH'(1);
                  end
               end
               ST_DRAIN: begin
                  if (pop) begin
                     send_cnt_reg <= send_cnt_reg + LEN_WIDTH'(1);
                     if (last_pop) begin
                        state_reg <= ST_IDLE;
                        busy_reg  <= 1'b0;
                        done_reg  <= 1'b1;
                     end
                  end
               end
               default: begin
                  state_reg <= ST_IDLE;
                  busy_reg  <= 1'b0;
               end
            endcase
         end
      end
   end

   // Capture is keyed on the in-flight flag; mem_rdata is meaningless otherwise.
   tx_skid_fifo #(
      .WIDTH(DATA_WIDTH)
   ) u_out_buf (
      .clk       (clk),
      .reset_n   (reset_n),
      .flush     (bus.abort),
      .push      (inflight_reg),
      .push_data (bus.mem_rdata),
      .pop       (pop),
      .pop_data  (head_data),
      .count     (fifo_count)
   );

   assign bus.busy     = busy_reg;
   assign bus.done     = done_reg;
   assign bus.mem_addr = addr_reg;
   assign bus.mem_wr   = 1'b0;
   assign bus.tx_data  = head_data;
   assign bus.tx_valid = tx_valid_int;
   assign bus.tx_last  = tx_valid_int && last_pop;

endmodule

// File: tb/tb_tx_mem_reader.sv
// Bench for tx_mem_reader: directed scenarios plus randomized traffic against a word-queue model.
module tb_tx_mem_reader;
   import tx_mem_reader_pkg::*;

   localparam int DW = 32;
   localparam int MD = 16;
   localparam int AW = 4;
   localparam int LW = 5;

   logic clk = 1'b0;
   logic reset_n = 1'b0;
   always #5 clk = ~clk;

   tx_mem_reader_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .LEN_WIDTH(LW)) bus ();

   tx_mem_reader #(
      .DATA_WIDTH(DW), .MEM_DEPTH(MD), .ADDR_WIDTH(AW), .LEN_WIDTH(LW)
   ) dut (
      .clk     (clk),
      .reset_n (reset_n),
      .bus     (bus)
   );

   // Synchronous-read memory on port 2.
   logic [DW-1:0] mem [MD];
   always @(posedge clk) bus.mem_rdata <= mem[bus.mem_addr];

   int checks = 0;
   int errors = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Reference model: expected words of the active transfer, in order.
   logic [DW-1:0] exp_q[$];
   bit            model_busy = 1'b0;
   bit            done_next = 1'b0;
   bit            prev_stall = 1'b0;
   logic [DW-1:0] prev_data = '0;
   logic          prev_last = 1'b0;
   bit            mon_hs;
   bit            mon_last;
   int            xfer_words = 0;
   int            last_xfer_words = -1;
   int            mon_len;

   always @(negedge clk) begin
      if (!reset_n) begin
         model_busy = 1'b0;
         done_next  = 1'b0;
         prev_stall = 1'b0;
         xfer_words = 0;
         exp_q.delete();
      end else begin
         chk("busy", 32'(bus.busy), 32'(model_busy));
         chk("done", 32'(bus.done), 32'(done_next));
         chk("mem_wr", 32'(bus.mem_wr), 32'd0);
         if (!model_busy) chk("idle_valid", 32'(bus.tx_valid), 32'd0);
         if (prev_stall) begin
            chk("stall_valid", 32'(bus.tx_valid), 32'd1);
            chk("stall_data", bus.tx_data, prev_data);
            chk("stall_last", 32'(bus.tx_last), 32'(prev_last));
         end
         mon_hs    = bus.tx_valid && bus.tx_ready;
         mon_last  = 1'b0;
         done_next = 1'b0;
         if (mon_hs) begin
            if (exp_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_word: got %0h expected none", bus.tx_data);
            end else begin
               mon_last = (exp_q.size() == 1);
               chk("word", bus.tx_data, exp_q[0]);
               chk("last", 32'(bus.tx_last), 32'(mon_last));
               void'(exp_q.pop_front());
               xfer_words++;
            end
         end
         prev_stall = bus.tx_valid && !bus.tx_ready && !bus.abort;
         prev_data  = bus.tx_data;
         prev_last  = bus.tx_last;
         if (bus.abort) begin
            if (model_busy) $display("xfer aborted after %0d words", xfer_words);
            model_busy = 1'b0;
            exp_q.delete();
         end else if (mon_hs && mon_last) begin
            model_busy      = 1'b0;
            done_next       = 1'b1;
            last_xfer_words = xfer_words;
            $display("xfer complete: %0d words", xfer_words);
         end else if (!model_busy && bus.start) begin
            mon_len = (int'(bus.length) > MD) ? MD : int'(bus.length);
            xfer_words = 0;
            if (mon_len == 0) begin
               done_next       = 1'b1;
               last_xfer_words = 0;
               $display("xfer complete: 0 words");
            end else begin
               for (int i = 0; i < mon_len; i++) exp_q.push_back(mem[(int'(bus.start_addr) + i) % MD]);
               model_busy = 1'b1;
            end
         end
      end
   end

   // tx_ready driver: 0 = held high, 1 = toggling, 2 = random, 3 = held low.
   int ready_mode = 0;
   initial begin
      bus.tx_ready = 1'b0;
      forever begin
         @(posedge clk);
         #2;
         case (ready_mode)
            0:       bus.tx_ready = 1'b1;
            1:       bus.tx_ready = ~bus.tx_ready;
            2:       bus.tx_ready = 1'($urandom_range(0, 1));
            default: bus.tx_ready = 1'b0;
         endcase
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic at_neg();
      @(negedge clk);
      #1;
   endtask

   task automatic start_xfer(input int addr, input int len);
      bus.start      = 1'b1;
      bus.start_addr = AW'(addr);
      bus.length     = LW'(len);
      step();
      bus.start = 1'b0;
   endtask

   task automatic wait_idle(input string name, input int budget);
      bit ok = 1'b0;
      for (int i = 0; i < budget; i++) begin
         at_neg();
         if (!model_busy) begin
            ok = 1'b1;
            break;
         end
      end
      checks++;
      if (!ok) begin
         errors++;
         $display("FAIL %s: still busy after %0d cycles, required idle", name, budget);
      end
   endtask

   logic [AW-1:0] exp_addr2 [4];
   logic [DW-1:0] exp_word2 [4];

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      bus.start      = 1'b0;
      bus.start_addr = '0;
      bus.length     = '0;
      bus.abort      = 1'b0;
      for (int i = 0; i < MD; i++) mem[i] = 32'hA0 + 32'(i);
      exp_addr2 = '{4'd14, 4'd15, 4'd0, 4'd1};
      exp_word2 = '{32'hAE, 32'hAF, 32'hA0, 32'hA1};

      repeat (2) @(posedge clk);
      #1;
      chk("rst_busy", 32'(bus.busy), 32'd0);
      chk("rst_valid", 32'(bus.tx_valid), 32'd0);
      chk("rst_addr", 32'(bus.mem_addr), 32'd0);
      chk("rst_data", bus.tx_data, 32'd0);
      reset_n = 1'b1;
      step();

      // 1: basic transfer, latency and back-to-back words
      start_xfer(0, 4);
      at_neg();
      chk("t1_addr_c1", 32'(bus.mem_addr), 32'd0);
      chk("t1_busy_c1", 32'(bus.busy), 32'd1);
      step(); at_neg();
      chk("t1_valid_c2", 32'(bus.tx_valid), 32'd0);
      for (int k = 0; k < 4; k++) begin
         step(); at_neg();
         chk("t1_valid", 32'(bus.tx_valid), 32'd1);
         chk("t1_data", bus.tx_data, 32'hA0 + 32'(k));
         chk("t1_last", 32'(bus.tx_last), 32'(k == 3));
      end
      step(); at_neg();
      chk("t1_done", 32'(bus.done), 32'd1);
      chk("t1_busy_end", 32'(bus.busy), 32'd0);
      step();

      // 2: address wrap
      start_xfer(14, 4);
      for (int c = 1; c <= 6; c++) begin
         at_neg();
         if (c <= 4) chk("t2_addr", 32'(bus.mem_addr), 32'(exp_addr2[c-1]));
         if (c >= 3) chk("t2_data", bus.tx_data, exp_word2[c-3]);
         step();
      end
      wait_idle("t2_idle", 20);
      chk("t2_words", 32'(last_xfer_words), 32'd4);
      step();

      // 3: toggling ready
      ready_mode = 1;
      start_xfer(5, 3);
      wait_idle("t3_idle", 40);
      chk("t3_words", 32'(last_xfer_words), 32'd3);
      ready_mode = 0;
      step();

      // 4: zero length and saturating length
      start_xfer(3, 0);
      at_neg();
      chk("t4_done0", 32'(bus.done), 32'd1);
      chk("t4_busy0", 32'(bus.busy), 32'd0);
      chk("t4_valid0", 32'(bus.tx_valid), 32'd0);
      step(); at_neg();
      chk("t4_done0_end", 32'(bus.done), 32'd0);
      step();
      start_xfer(7, 31);
      wait_idle("t4_idle31", 60);
      chk("t4_words31", 32'(last_xfer_words), 32'd16);
      step();

      // 5: abort after the second word
      start_xfer(0, 8);
      begin
         bit got = 1'b0;
         for (int i = 0; i < 20; i++) begin
            at_neg();
            if (xfer_words >= 2) begin
               got = 1'b1;
               break;
            end
         end
         checks++;
         if (!got) begin
            errors++;
            $display("FAIL t5_words: got %0d expected 2", xfer_words);
         end
      end
      step();
      bus.abort  = 1'b1;
      ready_mode = 3;
      step();
      bus.abort = 1'b0;
      at_neg();
      chk("t5_valid", 32'(bus.tx_valid), 32'd0);
      chk("t5_busy", 32'(bus.busy), 32'd0);
      chk("t5_done", 32'(bus.done), 32'd0);
      step(); at_neg();
      chk("t5_done2", 32'(bus.done), 32'd0);
      ready_mode = 0;
      step();
      start_xfer(9, 1);
      wait_idle("t5_idle", 20);
      chk("t5_words1", 32'(last_xfer_words), 32'd1);
      step();

      // 6: asynchronous reset mid-transfer, then start while busy
      start_xfer(2, 8);
      step(); step();
      #3;
      reset_n = 1'b0;
      #1;
      chk("t6_busy", 32'(bus.busy), 32'd0);
      chk("t6_valid", 32'(bus.tx_valid), 32'd0);
      chk("t6_last", 32'(bus.tx_last), 32'd0);
      chk("t6_done", 32'(bus.done), 32'd0);
      chk("t6_addr", 32'(bus.mem_addr), 32'd0);
      chk("t6_data", bus.tx_data, 32'd0);
      step(); step();
      reset_n = 1'b1;
      step();
      start_xfer(4, 5);
      bus.start  = 1'b1;
      bus.length = LW'(2);
      step();
      bus.start = 1'b0;
      wait_idle("t6_idle", 30);
      chk("t6_words", 32'(last_xfer_words), 32'd5);
      step();

      // Randomized traffic
      for (int i = 0; i < MD; i++) mem[i] = $urandom;
      ready_mode = 2;
      for (int n = 0; n < 400; n++) begin
         bus.start      = ($urandom_range(0, 5) == 0);
         bus.start_addr = AW'($urandom_range(0, MD - 1));
         bus.length     = LW'($urandom_range(0, 20));
         bus.abort      = ($urandom_range(0, 39) == 0);
         step();
      end
      bus.start  = 1'b0;
      bus.abort  = 1'b0;
      ready_mode = 0;
      wait_idle("rand_idle", 60);
      step();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
